fpga_serial_bus: RTL and testbench

- 16-station shared serial bus transmitter. Each station n (1..16) presents a 64-bit payload, a 4-bit destination address and a 4-bit CRC.
- A 16-bit request vector `mod` selects which stations want to send.
- The block arbitrates between requests, serialises one framed packet at a time onto a single-bit bus, and exposes that bus as `bus_show`.
- It sits at the top of the station network and is the only driver of the shared line.

---
 rtl/fpga_serial_bus.sv | 211 +++++++++++++++++++++
 tb/tb_fpga_serial_bus.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_serial_bus.sv
// -----------------------------------------------------------------------------
// fpga_serial_bus
//
// Shared single-wire bus transmitter for 16 stations. Each station offers a
// payload, a destination address and a check field; a rising edge on its bit
// of `mod` queues one frame. Queued stations are served lowest index first,
// one complete frame at a time, with one idle-1 guard bit between frames.
//
// Frame (77 bits, sent MSB first within each field):
//   start(0) | src[3:0] = station-1 | dst[3:0] | data[63:0] | crc[3:0]
//
// Ports:
//   clock            system clock, all logic on the rising edge
//   reset            synchronous, active-high
//   DataN            payload of station N (N = 1..16)
//   receiverAddrN    destination address carried in station N's frame
//   CRCN             check field carried verbatim in station N's frame
//   mod              request vector, bit N-1 belongs to station N
//   bus_show         registered serial line, idles at 1
// -----------------------------------------------------------------------------
module fpga_serial_bus #(
    parameter int NSTA      = 16,
    parameter int DW        = 64,
    parameter int FRAME_LEN = 77
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [DW-1:0]   Data1,
    input  logic [DW-1:0]   Data2,
    input  logic [DW-1:0]   Data3,
    input  logic [DW-1:0]   Data4,
    input  logic [DW-1:0]   Data5,
    input  logic [DW-1:0]   Data6,
    input  logic [DW-1:0]   Data7,
    input  logic [DW-1:0]   Data8,
    input  logic [DW-1:0]   Data9,
    input  logic [DW-1:0]   Data10,
    input  logic [DW-1:0]   Data11,
    input  logic [DW-1:0]   Data12,
    input  logic [DW-1:0]   Data13,
    input  logic [DW-1:0]   Data14,
    input  logic [DW-1:0]   Data15,
    input  logic [DW-1:0]   Data16,
    input  logic [3:0]      receiverAddr1,
    input  logic [3:0]      receiverAddr2,
    input  logic [3:0]      receiverAddr3,
    input  logic [3:0]      receiverAddr4,
    input  logic [3:0]      receiverAddr5,
    input  logic [3:0]      receiverAddr6,
    input  logic [3:0]      receiverAddr7,
    input  logic [3:0]      receiverAddr8,
    input  logic [3:0]      receiverAddr9,
    input  logic [3:0]      receiverAddr10,
    input  logic [3:0]      receiverAddr11,
    input  logic [3:0]      receiverAddr12,
    input  logic [3:0]      receiverAddr13,
    input  logic [3:0]      receiverAddr14,
    input  logic [3:0]      receiverAddr15,
    input  logic [3:0]      receiverAddr16,
    input  logic [3:0]      CRC1,
    input  logic [3:0]      CRC2,
    input  logic [3:0]      CRC3,
    input  logic [3:0]      CRC4,
    input  logic [3:0]      CRC5,
    input  logic [3:0]      CRC6,
    input  logic [3:0]      CRC7,
    input  logic [3:0]      CRC8,
    input  logic [3:0]      CRC9,
    input  logic [3:0]      CRC10,
    input  logic [3:0]      CRC11,
    input  logic [3:0]      CRC12,
    input  logic [3:0]      CRC13,
    input  logic [3:0]      CRC14,
    input  logic [3:0]      CRC15,
    input  logic [3:0]      CRC16,
    input  logic [NSTA-1:0] mod,
    output logic            bus_show
);

    // Bits still to send after the start bit, and a counter wide enough for
    // the frame index.
    localparam int SW = FRAME_LEN - 1;
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GUARD
    } state_e;

    // Station inputs gathered into arrays so the granted station is a plain
    // index instead of a 16-way case statement.
    logic [DW-1:0] data_a [NSTA];
    logic [3:0]    addr_a [NSTA];
    logic [3:0]    crc_a  [NSTA];

    assign data_a[0]  = Data1;   assign addr_a[0]  = receiverAddr1;   assign crc_a[0]  = CRC1;
    assign data_a[1]  = Data2;   assign addr_a[1]  = receiverAddr2;   assign crc_a[1]  = CRC2;
    assign data_a[2]  = Data3;   assign addr_a[2]  = receiverAddr3;   assign crc_a[2]  = CRC3;
    assign data_a[3]  = Data4;   assign addr_a[3]  = receiverAddr4;   assign crc_a[3]  = CRC4;
    assign data_a[4]  = Data5;   assign addr_a[4]  = receiverAddr5;   assign crc_a[4]  = CRC5;
    assign data_a[5]  = Data6;   assign addr_a[5]  = receiverAddr6;   assign crc_a[5]  = CRC6;
    assign data_a[6]  = Data7;   assign addr_a[6]  = receiverAddr7;   assign crc_a[6]  = CRC7;
    assign data_a[7]  = Data8;   assign addr_a[7]  = receiverAddr8;   assign crc_a[7]  = CRC8;
    assign data_a[8]  = Data9;   assign addr_a[8]  = receiverAddr9;   assign crc_a[8]  = CRC9;
    assign data_a[9]  = Data10;  assign addr_a[9]  = receiverAddr10;  assign crc_a[9]  = CRC10;
    assign data_a[10] = Data11;  assign addr_a[10] = receiverAddr11;  assign crc_a[10] = CRC11;
    assign data_a[11] = Data12;  assign addr_a[11] = receiverAddr12;  assign crc_a[11] = CRC12;
    assign data_a[12] = Data13;  assign addr_a[12] = receiverAddr13;  assign crc_a[12] = CRC13;
    assign data_a[13] = Data14;  assign addr_a[13] = receiverAddr14;  assign crc_a[13] = CRC14;
    assign data_a[14] = Data15;  assign addr_a[14] = receiverAddr15;  assign crc_a[14] = CRC15;
    assign data_a[15] = Data16;  assign addr_a[15] = receiverAddr16;  assign crc_a[15] = CRC16;

    state_e          state_q;
    logic [NSTA-1:0] mod_prev_q;
    logic [NSTA-1:0] pending_q;
    logic [NSTA-1:0] pending_d;
    logic [SW-1:0]   shreg_q;
    logic [SW-1:0]   shreg_d;
    logic [CW-1:0]   cnt_q;
    logic            bus_q;

    logic            grant_valid;
    logic [3:0]      grant_idx;
    logic            grant_take;
    logic [NSTA-1:0] grant_mask;
    logic [NSTA-1:0] mod_rise;

    assign bus_show = bus_q;

    // mod_prev is cleared by reset, so a request already high when reset
    // releases is seen as a rise on the first active edge.
    assign mod_rise = mod & ~mod_prev_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        // Scan from the top down so the lowest pending index is the last
        // one written and therefore wins.
        for (int i = NSTA - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_valid = 1'b1;
                grant_idx   = i[3:0];
            end
        end

        grant_take = (state_q == ST_IDLE) && grant_valid;
        grant_mask = grant_take ? (NSTA'(1) << grant_idx) : '0;

        // Clear the granted bit, then OR in new rises so a rise landing on
        // the grant edge re-queues the station.
        pending_d  = (pending_q & ~grant_mask) | mod_rise;

        // Frame minus its start bit; the start bit goes straight to the line.
        shreg_d    = {grant_idx, addr_a[grant_idx], data_a[grant_idx], crc_a[grant_idx]};
    end

    // NOTE: state registers are written with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mod_prev_q <= '0;
            pending_q  <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            bus_q      <= 1'b1;
        end else begin
            mod_prev_q <= mod;
            pending_q  <= pending_d;

            case (state_q)
                ST_IDLE: begin
                    if (grant_take) begin
                        bus_q   <= 1'b0;
                        shreg_q <= shreg_d;
                        cnt_q   <= CW'(1);
                        state_q <= ST_SEND;
                    end else begin
                        bus_q   <= 1'b1;
                    end
                end

                ST_SEND: begin
                    // cnt_q is the index of the bit placed on the line here.
                    bus_q   <= shreg_q[SW-1];
                    shreg_q <= shreg_q << 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAME_LEN - 1)) begin
                        state_q <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    // One idle-1 bit; the next edge may already arbitrate.
                    bus_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    bus_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_serial_bus.sv
// -----------------------------------------------------------------------------
// tb_fpga_serial_bus
//
// Self-checking bench for fpga_serial_bus. Expected frames are assembled
// from the station inputs held in the bench (start, src = station-1, dst,
// data, crc); the expected service order comes from the set of requesting
// stations in ascending order.
// -----------------------------------------------------------------------------
module tb_fpga_serial_bus;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] d_a [1:16];
    logic [3:0]  a_a [1:16];
    logic [3:0]  c_a [1:16];
    logic [15:0] mod;
    logic        bus_show;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fpga_serial_bus dut (
        .clock(clock), .reset(reset),
        .Data1(d_a[1]),   .Data2(d_a[2]),   .Data3(d_a[3]),   .Data4(d_a[4]),
        .Data5(d_a[5]),   .Data6(d_a[6]),   .Data7(d_a[7]),   .Data8(d_a[8]),
        .Data9(d_a[9]),   .Data10(d_a[10]), .Data11(d_a[11]), .Data12(d_a[12]),
        .Data13(d_a[13]), .Data14(d_a[14]), .Data15(d_a[15]), .Data16(d_a[16]),
        .receiverAddr1(a_a[1]),   .receiverAddr2(a_a[2]),   .receiverAddr3(a_a[3]),
        .receiverAddr4(a_a[4]),   .receiverAddr5(a_a[5]),   .receiverAddr6(a_a[6]),
        .receiverAddr7(a_a[7]),   .receiverAddr8(a_a[8]),   .receiverAddr9(a_a[9]),
        .receiverAddr10(a_a[10]), .receiverAddr11(a_a[11]), .receiverAddr12(a_a[12]),
        .receiverAddr13(a_a[13]), .receiverAddr14(a_a[14]), .receiverAddr15(a_a[15]),
        .receiverAddr16(a_a[16]),
        .CRC1(c_a[1]),   .CRC2(c_a[2]),   .CRC3(c_a[3]),   .CRC4(c_a[4]),
        .CRC5(c_a[5]),   .CRC6(c_a[6]),   .CRC7(c_a[7]),   .CRC8(c_a[8]),
        .CRC9(c_a[9]),   .CRC10(c_a[10]), .CRC11(c_a[11]), .CRC12(c_a[12]),
        .CRC13(c_a[13]), .CRC14(c_a[14]), .CRC15(c_a[15]), .CRC16(c_a[16]),
        .mod(mod),
        .bus_show(bus_show)
    );

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [76:0] exp_frame(input int n);
        logic [3:0] src;
        src = 4'(n - 1);
        return {1'b0, src, a_a[n], d_a[n], c_a[n]};
    endfunction

    task automatic randomize_inputs();
        for (int n = 1; n <= 16; n++) begin
            d_a[n] = {$urandom, $urandom};
            a_a[n] = 4'($urandom_range(0, 15));
            c_a[n] = 4'($urandom_range(0, 15));
        end
    endtask

    // Wait (bounded) for a start bit and capture the whole frame, frame bit k
    // landing in f[76-k]. waited = edges until the start bit, -1 on timeout.
    // mut=1 changes Data1 and raises mod[1] while bit 30 is being sent.
    task automatic get_frame(input int mut, output int waited, output logic [76:0] f);
        waited = -1;
        f      = '1;
        for (int w = 1; w <= 400; w++) begin
            tick();
            if (bus_show === 1'b0) begin
                waited = w;
                break;
            end
        end
        if (waited < 0) return;
        f[76] = 1'b0;
        for (int k = 1; k < 77; k++) begin
            if (mut == 1 && k == 30) begin
                d_a[1] = ~d_a[1];
                mod    = 16'h0003;
            end
            tick();
            f[76-k] = bus_show;
        end
    endtask

    task automatic check_guard(input string name);
        tick();
        n_checks++;
        if (bus_show !== 1'b1) begin
            n_fail++;
            $display("FAIL %s guard: bus_show=%b required 1", name, bus_show);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus_show !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s idle: %0d non-idle cycles, required 0", name, bad);
        end
    endtask

    task automatic quiesce();
        mod = 16'h0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        int          waited;
        logic [76:0] f;
        logic [76:0] e;
        reset = 1'b1;
        mod   = 16'hFFFF;
        randomize_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus_show !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: bus_show=%b required 1", i, bus_show);
            end
        end
        e     = exp_frame(1);
        reset = 1'b0;
        get_frame(0, waited, f);
        n_checks++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL reset_release_latency: %0d edges required 2", waited);
        end
        n_checks++;
        if (f !== e) begin
            n_fail++;
            $display("FAIL reset_release_frame: got %h required %h", f, e);
        end
        reset = 1'b1;
        mod   = 16'h0000;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int          waited;
        logic [76:0] f;
        logic [76:0] e;
        quiesce();
        d_a[1] = 64'd1;
        a_a[1] = 4'd1;
        c_a[1] = 4'd1;
        e      = {1'b0, 4'b0000, 4'b0001, 64'd1, 4'b0001};
        mod    = 16'h0001;
        get_frame(0, waited, f);
        n_checks++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL single_latency: %0d edges required 2", waited);
        end
        n_checks++;
        if (f !== e) begin
            n_fail++;
            $display("FAIL single_frame: got %h required %h", f, e);
        end
        check_guard("single");
        check_idle("single_hold", 100);
    endtask

    task automatic test_second_station();
        int          waited;
        logic [76:0] f;
        logic [76:0] e;
        d_a[2] = 64'd0;
        a_a[2] = 4'd2;
        c_a[2] = 4'd1;
        e      = {1'b0, 4'b0001, 4'b0010, 64'd0, 4'b0001};
        mod    = 16'h0002;
        get_frame(0, waited, f);
        n_checks++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL second_latency: %0d edges required 2", waited);
        end
        n_checks++;
        if (f !== e) begin
            n_fail++;
            $display("FAIL second_frame: got %h required %h", f, e);
        end
        check_guard("second");
        check_idle("second_hold", 50);
    endtask

    // Requests raised together must come out in ascending station order,
    // each frame one idle bit after the previous one.
    task automatic run_contention(input logic [15:0] mask, input string name);
        int          order[$];
        int          waited;
        logic [76:0] f;
        logic [76:0] e;
        quiesce();
        randomize_inputs();
        for (int n = 1; n <= 16; n++) begin
            if (mask[n-1]) order.push_back(n);
        end
        mod = mask;
        foreach (order[j]) begin
            e = exp_frame(order[j]);
            get_frame(0, waited, f);
            n_checks++;
            if (waited !== ((j == 0) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL %s gap before station %0d: %0d edges required %0d",
                         name, order[j], waited, (j == 0) ? 2 : 1);
            end
            n_checks++;
            if (f !== e) begin
                n_fail++;
                $display("FAIL %s station %0d frame: got %h required %h", name, order[j], f, e);
            end
            check_guard(name);
        end
        check_idle(name, 20);
    endtask

    task automatic test_contention();
        logic [15:0] mask;
        run_contention(16'h8005, "contention_8005");
        for (int r = 0; r < 3; r++) begin
            mask = 16'($urandom_range(1, 16'hFFFF));
            run_contention(mask, "contention_rand");
        end
    endtask

    task automatic test_back_to_back();
        int          waited;
        logic [76:0] f;
        logic [76:0] e1;
        logic [76:0] e2;
        quiesce();
        randomize_inputs();
        e1  = exp_frame(1);
        mod = 16'h0001;
        get_frame(1, waited, f);
        n_checks++;
        if (f !== e1) begin
            n_fail++;
            $display("FAIL snapshot_frame1: got %h required %h", f, e1);
        end
        check_guard("snapshot");
        e2 = exp_frame(2);
        get_frame(0, waited, f);
        n_checks++;
        if (waited !== 1) begin
            n_fail++;
            $display("FAIL snapshot_gap: %0d edges required 1", waited);
        end
        n_checks++;
        if (f !== e2) begin
            n_fail++;
            $display("FAIL snapshot_frame2: got %h required %h", f, e2);
        end
        check_guard("snapshot2");
        check_idle("snapshot_hold", 20);
    endtask

    task automatic test_reset_mid_frame();
        int          waited;
        logic [76:0] f;
        logic [76:0] e;
        logic        seen;
        quiesce();
        randomize_inputs();
        e    = exp_frame(1);
        mod  = 16'h0003;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            tick();
            if (bus_show === 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_start: no start bit seen, required one within 10 edges");
        end
        for (int k = 1; k <= 30; k++) tick();
        n_checks++;
        if (bus_show !== e[76-30]) begin
            n_fail++;
            $display("FAIL midreset_bit30: bus_show=%b required %b", bus_show, e[76-30]);
        end
        reset = 1'b1;
        mod   = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus_show !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset_abort cycle %0d: bus_show=%b required 1", i, bus_show);
            end
        end
        reset = 1'b0;
        get_frame(0, waited, f);
        n_checks++;
        if (waited !== 2) begin
            n_fail++;
            $display("FAIL midreset_restart_latency: %0d edges required 2", waited);
        end
        n_checks++;
        if (f !== e) begin
            n_fail++;
            $display("FAIL midreset_restart_frame: got %h required %h", f, e);
        end
        check_guard("midreset");
        // Station 2's request was discarded by the reset.
        check_idle("midreset_hold", 100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mod   = 16'h0000;
        randomize_inputs();
        test_reset();
        test_single_frame();
        test_second_station();
        test_contention();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
